// File: rtl/aes_roundtrip_seq.sv
// aes_roundtrip_seq: handshake-driven encrypt->decrypt self-test sequencer.
// Ports: clk/reset_n; start, key_sel, loop_en, seed (run control);
//   enc_*/dec_* (start/done handshake to the AES cores);
//   busy, done, pass, fail_sticky, timeout_err, cfg_err (status);
//   cipher_q, result_q (last captured blocks); iter_cnt, fail_cnt (stats).
module aes_roundtrip_seq #(
    parameter int DATA_W  = 128,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        key_sel,
    input  logic              loop_en,
    input  logic [DATA_W-1:0] seed,
    output logic              enc_start,
    output logic [1:0]        enc_key_sel,
    output logic [DATA_W-1:0] enc_din,
    input  logic [DATA_W-1:0] enc_dout,
    input  logic              enc_done,
    output logic              dec_start,
    output logic [1:0]        dec_key_sel,
    output logic [DATA_W-1:0] dec_din,
    input  logic [DATA_W-1:0] dec_dout,
    input  logic              dec_done,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail_sticky,
    output logic              timeout_err,
    output logic              cfg_err,
    output logic [DATA_W-1:0] cipher_q,
    output logic [DATA_W-1:0] result_q,
    output logic [CNT_W-1:0]  iter_cnt,
    output logic [CNT_W-1:0]  fail_cnt
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        ENC_REQ,
        ENC_WAIT,
        DEC_REQ,
        DEC_WAIT,
        CHECK
    } state_t;

    state_t            state;
    logic [1:0]        key_q;
    logic [DATA_W-1:0] pt;
    logic [TW-1:0]     tmo;

    // Key and both data buses come straight from registers.
    assign enc_key_sel = key_q;
    assign dec_key_sel = key_q;
    assign enc_din     = pt;
    assign dec_din     = cipher_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            key_q       <= 2'b00;
            pt          <= '0;
            tmo         <= '0;
            enc_start   <= 1'b0;
            dec_start   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail_sticky <= 1'b0;
            timeout_err <= 1'b0;
            cfg_err     <= 1'b0;
            cipher_q    <= '0;
            result_q    <= '0;
            iter_cnt    <= '0;
            fail_cnt    <= '0;
        end else begin
            enc_start <= 1'b0;
            dec_start <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (key_sel == 2'b11) begin
                            cfg_err <= 1'b1;
                        end else begin
                            key_q       <= key_sel;
                            pt          <= seed;
                            iter_cnt    <= '0;
                            fail_cnt    <= '0;
                            timeout_err <= 1'b0;
                            cfg_err     <= 1'b0;
                            enc_start   <= 1'b1;
                            busy        <= 1'b1;
                            state       <= ENC_REQ;
                        end
                    end
                end
                ENC_REQ: begin
                    tmo   <= '0;
                    state <= ENC_WAIT;
                end
                ENC_WAIT: begin
                    // done on the terminal-count cycle still wins
                    if (enc_done) begin
                        cipher_q  <= enc_dout;
                        dec_start <= 1'b1;
                        state     <= DEC_REQ;
                    end else if (tmo == TMO_LAST) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        tmo <= tmo + TW'(1);
                    end
                end
                DEC_REQ: begin
                    tmo   <= '0;
                    state <= DEC_WAIT;
                end
                DEC_WAIT: begin
                    // Result is judged on capture so done/pass/counters
                    // are all valid during the CHECK cycle.
                    if (dec_done) begin
                        result_q <= dec_dout;
                        done     <= 1'b1;
                        pass     <= (dec_dout == pt);
                        iter_cnt <= sat_inc(iter_cnt);
                        if (dec_dout != pt) begin
                            fail_cnt    <= sat_inc(fail_cnt);
                            fail_sticky <= 1'b1;
                        end
                        state <= CHECK;
                    end else if (tmo == TMO_LAST) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        tmo <= tmo + TW'(1);
                    end
                end
                CHECK: begin
                    if (loop_en) begin
                        pt        <= pt + DATA_W'(1);
                        enc_start <= 1'b1;
                        state     <= ENC_REQ;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_roundtrip_seq.sv
// Bench for aes_roundtrip_seq: model AES cores with programmable latency,
// expected done pulses queued at issue time and checked by a monitor.
`timescale 1ns/1ps
module tb_aes_roundtrip_seq;

    localparam int DW = 128;
    localparam logic [DW-1:0] SEED0 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [DW-1:0] CT0   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [DW-1:0] MASK  = SEED0 ^ CT0;

    logic          clk;
    logic          reset_n;
    logic          start;
    logic [1:0]    key_sel;
    logic          loop_en;
    logic [DW-1:0] seed;
    logic          enc_start, dec_start;
    logic [1:0]    enc_key_sel, dec_key_sel;
    logic [DW-1:0] enc_din, dec_din;
    logic [DW-1:0] enc_dout, dec_dout;
    logic          enc_done, dec_done;
    logic          enc_done_m, stray;
    logic          busy, done, pass, fail_sticky, timeout_err, cfg_err;
    logic [DW-1:0] cipher_q, result_q;
    logic [1:0]    iter_cnt, fail_cnt;

    assign enc_done = enc_done_m | stray;

    aes_roundtrip_seq #(.DATA_W(DW), .CNT_W(2), .TIMEOUT(64)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .key_sel(key_sel),
        .loop_en(loop_en), .seed(seed),
        .enc_start(enc_start), .enc_key_sel(enc_key_sel), .enc_din(enc_din),
        .enc_dout(enc_dout), .enc_done(enc_done),
        .dec_start(dec_start), .dec_key_sel(dec_key_sel), .dec_din(dec_din),
        .dec_dout(dec_dout), .dec_done(dec_done),
        .busy(busy), .done(done), .pass(pass), .fail_sticky(fail_sticky),
        .timeout_err(timeout_err), .cfg_err(cfg_err),
        .cipher_q(cipher_q), .result_q(result_q),
        .iter_cnt(iter_cnt), .fail_cnt(fail_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] kmask(input logic [1:0] k);
        return MASK ^ {118'd0, k, 8'd0};
    endfunction

    // Core model controls
    int         enc_lat = 1, dec_lat = 1;
    bit         enc_never = 0;
    int         dec_n = 0, corrupt_iter = 0;
    logic [1:0] exp_key = 2'b00;
    bit         sticky_m = 0;

    typedef struct {
        int            cyc;
        logic          pass;
        logic [DW-1:0] ct;
        logic [DW-1:0] res;
        logic [1:0]    it;
        logic [1:0]    fc;
        logic          st;
    } exp_t;
    exp_t sbq[$];

    // Encrypt core model
    initial begin : enc_model
        logic [DW-1:0] din;
        logic [1:0]    k;
        enc_done_m = 1'b0;
        enc_dout   = '1;
        forever begin
            @(negedge clk);
            if (enc_start === 1'b1) begin
                din = enc_din;
                k   = enc_key_sel;
                chk("enc_key_sel", {126'd0, k}, {126'd0, exp_key});
                if (!enc_never) begin
                    repeat (enc_lat) @(negedge clk);
                    enc_done_m = 1'b1;
                    enc_dout   = din ^ kmask(k);
                    @(negedge clk);
                    enc_done_m = 1'b0;
                    enc_dout   = '1;
                end
            end
        end
    end

    // Decrypt core model, optionally corrupting one iteration
    initial begin : dec_model
        logic [DW-1:0] y;
        logic [1:0]    k;
        dec_done = 1'b0;
        dec_dout = '1;
        forever begin
            @(negedge clk);
            if (dec_start === 1'b1) begin
                y = dec_din;
                k = dec_key_sel;
                chk("dec_key_sel", {126'd0, k}, {126'd0, exp_key});
                dec_n++;
                repeat (dec_lat) @(negedge clk);
                dec_done = 1'b1;
                dec_dout = y ^ kmask(k);
                if (dec_n == corrupt_iter) dec_dout[0] = ~dec_dout[0];
                @(negedge clk);
                dec_done = 1'b0;
                dec_dout = '1;
            end
        end
    end

    // Monitor: every done pulse must match the head of the queue
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got done=1 at cyc %0d want none",
                             cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("done_cycle", DW'(cyc), DW'(e.cyc));
                    chk("pass", {127'd0, pass}, {127'd0, e.pass});
                    chk("cipher_q", cipher_q, e.ct);
                    chk("result_q", result_q, e.res);
                    chk("iter_cnt", {126'd0, iter_cnt}, {126'd0, e.it});
                    chk("fail_cnt", {126'd0, fail_cnt}, {126'd0, e.fc});
                    chk("fail_sticky", {127'd0, fail_sticky}, {127'd0, e.st});
                end
            end
        end
    end

    // One run of n iterations; queues expectations, then waits for them.
    task automatic run(input logic [1:0] k, input logic [DW-1:0] sd,
                       input int n, input int le, input int ld, input int ci);
        int            s, seen, budget, lim;
        exp_t          e;
        logic [1:0]    itm, fcm;
        logic [DW-1:0] p;
        enc_lat = le;
        dec_lat = ld;
        corrupt_iter = ci;
        dec_n = 0;
        exp_key = k;
        enc_never = 0;
        itm = 2'd0;
        fcm = 2'd0;
        @(negedge clk);
        s = cyc;
        for (int i = 0; i < n; i++) begin
            p      = sd + DW'(i);
            e.cyc  = s + (i + 1) * (le + ld + 3);
            e.ct   = p ^ kmask(k);
            e.pass = ((i + 1) != ci);
            e.res  = e.pass ? p : (p ^ DW'(1));
            if (itm != 2'd3) itm = itm + 2'd1;
            if (!e.pass) begin
                if (fcm != 2'd3) fcm = fcm + 2'd1;
                sticky_m = 1;
            end
            e.it = itm;
            e.fc = fcm;
            e.st = sticky_m;
            sbq.push_back(e);
        end
        key_sel = k;
        seed    = sd;
        loop_en = (n > 1);
        start   = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        seen   = 0;
        budget = 0;
        lim    = n * (le + ld + 3) + 20;
        while (seen < n && budget < lim) begin
            if (done === 1'b1) begin
                seen++;
                if (seen == n) loop_en = 1'b0;
            end
            @(negedge clk);
            budget++;
        end
        chk("done_count", DW'(seen), DW'(n));
        chk("busy_after_run", {127'd0, busy}, 128'd0);
    endtask

    initial begin : stim
        int s;
        reset_n = 1'b0;
        start   = 1'b0;
        key_sel = 2'b00;
        loop_en = 1'b0;
        seed    = '0;
        stray   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_flags", {122'd0, enc_start, dec_start, done, pass,
                          fail_sticky, timeout_err}, 128'd0);
        chk("rst_cipher", cipher_q, 128'd0);
        chk("rst_cnts", {124'd0, iter_cnt, fail_cnt}, 128'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // 128-bit single run
        run(2'b00, SEED0, 1, 11, 11, 0);
        chk("t1_cipher", cipher_q, CT0);
        chk("t1_pass", {127'd0, pass}, 128'd1);

        // 256-bit loop, three iterations
        run(2'b10, 128'h0123_4567_89ab_cdef_0000_0000_ffff_fffe, 3, 15, 15, 0);

        // Corrupt decrypt on iteration 2 of 4 (counters saturate at 3)
        run(2'b00, 128'hdead_beef_0000_1111_2222_3333_4444_5554, 4, 3, 5, 2);
        chk("t3_sticky", {127'd0, fail_sticky}, 128'd1);
        chk("t3_fail_cnt", {126'd0, fail_cnt}, 128'd1);

        // Encrypt core never answers
        enc_never = 1;
        exp_key = 2'b01;
        @(negedge clk);
        s = cyc;
        key_sel = 2'b01;
        seed = 128'h5;
        loop_en = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (64) @(negedge clk);
        chk("tmo_cyc", DW'(cyc), DW'(s + 65));
        chk("tmo_before", {126'd0, busy, timeout_err}, 128'b10);
        @(negedge clk);
        chk("tmo_after", {126'd0, busy, timeout_err}, 128'b01);
        chk("tmo_iter", {126'd0, iter_cnt}, 128'd0);
        enc_never = 0;
        repeat (3) @(negedge clk);

        // Done exactly on the terminal-count cycle
        run(2'b00, 128'h77, 1, 64, 2, 0);
        chk("term_tmo_clr", {127'd0, timeout_err}, 128'd0);

        // Reserved key size
        key_sel = 2'b11;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("cfg_err", {127'd0, cfg_err}, 128'd1);
        chk("cfg_idle", {126'd0, busy, enc_start}, 128'd0);

        // Stray encrypt done in IDLE
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        @(negedge clk);
        chk("stray_busy", {126'd0, busy, dec_start}, 128'd0);
        chk("stray_cipher", cipher_q, 128'h77 ^ kmask(2'b00));

        // Start pulse while busy must be ignored
        fork
            run(2'b01, 128'h1000, 1, 4, 4, 0);
            begin
                repeat (4) @(negedge clk);
                start = 1'b1;
                seed = 128'hbad;
                @(negedge clk);
                start = 1'b0;
            end
        join
        chk("cfg_err_clr", {127'd0, cfg_err}, 128'd0);
        repeat (4) @(negedge clk);

        // Asynchronous reset during DEC_WAIT
        enc_lat = 5;
        dec_lat = 20;
        exp_key = 2'b00;
        dec_n = 0;
        corrupt_iter = 0;
        key_sel = 2'b00;
        seed = 128'habc;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("ar_busy_pre", {127'd0, busy}, 128'd1);
        #2;
        reset_n = 1'b0;
        sticky_m = 0;
        #1;
        chk("ar_flags", {120'd0, enc_start, dec_start, busy, done, pass,
                         fail_sticky, timeout_err, cfg_err}, 128'd0);
        chk("ar_cipher", cipher_q, 128'd0);
        chk("ar_result", result_q, 128'd0);
        chk("ar_cnts", {122'd0, enc_key_sel, iter_cnt, fail_cnt}, 128'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (30) @(negedge clk);
        run(2'b10, 128'h42, 1, 2, 3, 0);

        repeat (3) @(negedge clk);
        chk("sb_empty", DW'(sbq.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got no finish want finish by 500us");
        $fatal(1, "watchdog expired");
    end

endmodule
